sw_run_controller: RTL and testbench

SW_RUN_CONTROLLER -- requirements
Module: sw_run_controller

---
 rtl/sw_run_controller.sv | 110 +++++++++++
 tb/tb_sw_run_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_run_controller.sv
// Stopwatch run controller: command edge detection, run/pause FSM, one-second prescaler,
// lap display hold and sticky 99:59 overflow.
module sw_run_controller #(
    parameter int unsigned TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       reset,
    input  logic       lap,
    input  logic [6:0] minutes,
    input  logic [5:0] seconds,
    output logic       count_en,
    output logic       count_clr,
    output logic [1:0] current_state,
    output logic [6:0] disp_min,
    output logic [5:0] disp_sec,
    output logic       lap_hold,
    output logic       ovf
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRunning = 2'b01,
        StPaused  = 2'b10
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          start_q, stop_q, reset_q, lap_q;
    logic [6:0]    lap_min;
    logic [5:0]    lap_sec;

    logic reset_ev, stop_ev, start_ev, lap_ev;
    logic running, tick, at_max;

    // Priority-resolved events: reset > stop > start > lap.
    assign reset_ev = reset & ~reset_q;
    assign stop_ev  = stop & ~stop_q & ~reset_ev;
    assign start_ev = start & ~start_q & ~reset_ev & ~stop_ev;
    assign lap_ev   = lap & ~lap_q & ~reset_ev & ~stop_ev & ~start_ev;

    assign running = (state == StRunning);
    assign tick    = running && (presc == PRESC_LAST);
    assign at_max  = (minutes == 7'd99) && (seconds == 6'd59);

    // Combinational so an asynchronous rst drops it without waiting for a clock edge.
    assign count_en      = tick && !at_max && !count_clr;
    assign current_state = state;
    assign disp_min      = lap_hold ? lap_min : minutes;
    assign disp_sec      = lap_hold ? lap_sec : seconds;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            presc     <= '0;
            lap_min   <= '0;
            lap_sec   <= '0;
            lap_hold  <= 1'b0;
            ovf       <= 1'b0;
            count_clr <= 1'b0;
            // History of 1 keeps a command held through reset release from firing.
            start_q   <= 1'b1;
            stop_q    <= 1'b1;
            reset_q   <= 1'b1;
            lap_q     <= 1'b1;
        end else begin
            start_q   <= start;
            stop_q    <= stop;
            reset_q   <= reset;
            lap_q     <= lap;
            count_clr <= reset_ev;

            if (reset_ev) begin
                state    <= StIdle;
                presc    <= '0;
                lap_hold <= 1'b0;
                ovf      <= 1'b0;
            end else begin
                if (running) begin
                    presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                end

                if (tick && at_max) begin
                    ovf   <= 1'b1;
                    state <= StPaused;
                end else if (stop_ev && running) begin
                    state <= StPaused;
                end else if (start_ev && !ovf && !running) begin
                    state <= StRunning;
                end

                if (lap_ev) begin
                    if (lap_hold) begin
                        lap_hold <= 1'b0;
                    end else if (running) begin
                        lap_min  <= minutes;
                        lap_sec  <= seconds;
                        lap_hold <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sw_run_controller.sv
// Bench for sw_run_controller: bench-side mm:ss datapath, behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized commands.
module tb_sw_run_controller;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst, start, stop, reset, lap;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       count_en, count_clr, lap_hold, ovf;
    logic [1:0] current_state;
    logic [6:0] disp_min;
    logic [5:0] disp_sec;
    logic       force_max;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: mode 0 idle / 1 running / 2 paused, runs = running cycles since clear.
    int m_mode, m_runs, m_lap_min, m_lap_sec;
    bit m_hold, m_ovf, m_clr;
    bit h_start, h_stop, h_reset, h_lap;

    always #5 clk = ~clk;

    sw_run_controller #(.TICKS_PER_SEC(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .reset         (reset),
        .lap           (lap),
        .minutes       (minutes),
        .seconds       (seconds),
        .count_en      (count_en),
        .count_clr     (count_clr),
        .current_state (current_state),
        .disp_min      (disp_min),
        .disp_sec      (disp_sec),
        .lap_hold      (lap_hold),
        .ovf           (ovf)
    );

    // Stopwatch counter datapath driven by the controller strobes.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            minutes <= 7'd0;
            seconds <= 6'd0;
        end else if (force_max) begin
            minutes <= 7'd99;
            seconds <= 6'd59;
        end else if (count_clr) begin
            minutes <= 7'd0;
            seconds <= 6'd0;
        end else if (count_en) begin
            if (seconds == 6'd59) begin
                seconds <= 6'd0;
                minutes <= minutes + 7'd1;
            end else begin
                seconds <= seconds + 6'd1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_runs = 0; m_lap_min = 0; m_lap_sec = 0;
        m_hold = 0; m_ovf = 0; m_clr = 0;
        h_start = 1; h_stop = 1; h_reset = 1; h_lap = 1;
    endtask

    task automatic model_check();
        bit tick, at_max;
        tick   = (m_mode == 1) && (m_runs % T == T - 1);
        at_max = (int'(minutes) == 99) && (int'(seconds) == 59);
        chk("state", int'(current_state), m_mode);
        chk("count_en", int'(count_en), int'(tick && !at_max && !m_clr));
        chk("count_clr", int'(count_clr), int'(m_clr));
        chk("lap_hold", int'(lap_hold), int'(m_hold));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("disp_min", int'(disp_min), m_hold ? m_lap_min : int'(minutes));
        chk("disp_sec", int'(disp_sec), m_hold ? m_lap_sec : int'(seconds));
    endtask

    task automatic model_advance();
        bit e_r, e_s, e_g, e_l, tick, at_max;
        int nm;
        e_r = reset && !h_reset;
        e_s = stop && !h_stop && !e_r;
        e_g = start && !h_start && !e_r && !e_s;
        e_l = lap && !h_lap && !e_r && !e_s && !e_g;
        tick   = (m_mode == 1) && (m_runs % T == T - 1);
        at_max = (int'(minutes) == 99) && (int'(seconds) == 59);
        if (e_r) begin
            m_mode = 0; m_runs = 0; m_hold = 0; m_ovf = 0; m_clr = 1;
        end else begin
            m_clr = 0;
            nm = m_mode;
            if (tick && at_max) begin
                m_ovf = 1;
                nm = 2;
            end else if (e_s && m_mode == 1) begin
                nm = 2;
            end else if (e_g && !m_ovf && m_mode != 1) begin
                nm = 1;
            end
            if (e_l) begin
                if (m_hold) begin
                    m_hold = 0;
                end else if (m_mode == 1) begin
                    m_hold = 1;
                    m_lap_min = int'(minutes);
                    m_lap_sec = int'(seconds);
                end
            end
            if (m_mode == 1) m_runs++;
            m_mode = nm;
        end
        h_start = start; h_stop = stop; h_reset = reset; h_lap = lap;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return 1 after the rise.
    task automatic step();
        @(negedge clk);
        if (rst) model_reset();
        else begin
            model_check();
            model_advance();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; reset = 1'b0; lap = 1'b0; force_max = 1'b0;
        model_reset();
        #1;
        chk("rst_state", int'(current_state), 0);
        chk("rst_count_en", int'(count_en), 0);
        chk("rst_count_clr", int'(count_clr), 0);
        chk("rst_lap_hold", int'(lap_hold), 0);
        chk("rst_ovf", int'(ovf), 0);
        repeat (3) step();
        rst = 1'b0;
        step(); step();

        // Start from idle, ticks every 4th running cycle.
        start = 1'b1; step(); start = 1'b0;
        chk("start_to_running", int'(current_state), 1);
        for (int i = 1; i <= 12; i++) begin
            chk("tick_cycle", int'(count_en), int'(i % 4 == 0));
            step();
        end

        // Stop two running cycles past a tick; partial second survives the pause.
        step();
        stop = 1'b1; step(); stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("paused_state", int'(current_state), 2);
            chk("paused_no_tick", int'(count_en), 0);
            step();
        end
        start = 1'b1; step(); start = 1'b0;
        chk("resume_first", int'(count_en), 0);
        step();
        chk("resume_second", int'(count_en), 1);
        step();

        // Simultaneous commands.
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("start_stop_pause", int'(current_state), 2);
        step();
        reset = 1'b1; start = 1'b1; step(); reset = 1'b0; start = 1'b0;
        chk("reset_start_idle", int'(current_state), 0);
        chk("reset_clr_pulse", int'(count_clr), 1);
        step();
        chk("reset_clr_once", int'(count_clr), 0);

        // Overflow at 99:59.
        start = 1'b1; step(); start = 1'b0;
        force_max = 1'b1; step(); force_max = 1'b0;
        step(); step();
        chk("ovf_tick_suppressed", int'(count_en), 0);
        step();
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_paused", int'(current_state), 2);
        start = 1'b1; step(); start = 1'b0;
        chk("ovf_start_ignored", int'(current_state), 2);
        reset = 1'b1; step(); reset = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);
        chk("ovf_reset_idle", int'(current_state), 0);
        step();

        // Lap freezes display while the datapath keeps counting.
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (seconds != 6'd5 && n < 60) begin step(); n++; end
        chk("reach_00_05", int'(seconds), 5);
        lap = 1'b1; step(); lap = 1'b0;
        n = 0;
        while (seconds != 6'd7 && n < 60) begin step(); n++; end
        chk("reach_00_07", int'(seconds), 7);
        chk("lap_disp_sec", int'(disp_sec), 5);
        chk("lap_disp_min", int'(disp_min), 0);
        chk("lap_held", int'(lap_hold), 1);
        lap = 1'b1; step(); lap = 1'b0;
        chk("lap_released", int'(lap_hold), 0);
        chk("lap_live_sec", int'(disp_sec), 7);

        // Asynchronous rst mid-run with start held.
        n = 0;
        while (count_en != 1'b1 && n < 8) begin step(); n++; end
        chk("find_tick", int'(count_en), 1);
        start = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_count_en", int'(count_en), 0);
        chk("async_state", int'(current_state), 0);
        chk("async_count_clr", int'(count_clr), 0);
        chk("async_ovf", int'(ovf), 0);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_start_no_run", int'(current_state), 0);
        end
        start = 1'b0; step();
        start = 1'b1; step(); start = 1'b0;
        chk("restart_after_release", int'(current_state), 1);

        // Randomized commands against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) start = ~start;
            if ($urandom_range(0, 7) == 0) stop = ~stop;
            if ($urandom_range(0, 15) == 0) reset = ~reset;
            if ($urandom_range(0, 5) == 0) lap = ~lap;
            force_max = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; force_max = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
